// File: rtl/logo_motion_controller.sv
// logo_motion_controller: per-frame bouncing logo position, direction, palette index and bounce/corner pulses
module logo_motion_controller #(
  parameter int LOGO_SIZE = 128,
  parameter int DISPLAY_WIDTH = 640,
  parameter int DISPLAY_HEIGHT = 480,
  parameter int START_X = 200,
  parameter int START_Y = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] vpos,
  input  logic [2:0] speed,
  input  logic       pause,
  input  logic       step,
  output logic [9:0] logo_left,
  output logic [9:0] logo_top,
  output logic       dir_x,
  output logic       dir_y,
  output logic [2:0] color_index,
  output logic       bounce,
  output logic       corner_hit,
  output logic       busy
);
  localparam logic [10:0] MAX_X = 11'(DISPLAY_WIDTH - LOGO_SIZE);
  localparam logic [10:0] MAX_Y = 11'(DISPLAY_HEIGHT - LOGO_SIZE);
  typedef enum logic [1:0] {IDLE, CALC_X, CALC_Y, COMMIT} state_t;
  state_t state, state_next;
  logic [9:0] prev_vpos, nx, ny, calc_pos;
  logic [2:0] spd;
  logic step_pending, accept, ndx, ndy, hx, hy, on_y, cur_dir, hit_fwd, hit_back, calc_hit;
  logic [10:0] cur, lim, fwd, spd_w;
  always_comb begin
    on_y = state == CALC_Y;
    cur = {1'b0, on_y ? logo_top : logo_left};
    lim = on_y ? MAX_Y : MAX_X;
    cur_dir = on_y ? dir_y : dir_x;
    spd_w = {8'd0, spd};
    fwd = cur + spd_w;
    hit_fwd = spd != 3'd0 && fwd >= lim;
    hit_back = spd != 3'd0 && cur <= spd_w;
    calc_hit = cur_dir ? hit_fwd : hit_back;
    calc_pos = cur_dir ? (hit_fwd ? lim[9:0] : fwd[9:0]) : (hit_back ? 10'd0 : cur[9:0] - spd_w[9:0]);
    accept = vpos == 10'd0 && prev_vpos != 10'd0 && state == IDLE && (!pause || step_pending);
    state_next = state == IDLE ? (accept ? CALC_X : IDLE) : state == CALC_X ? CALC_Y : state == CALC_Y ? COMMIT : IDLE;
  end
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_next;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_vpos <= '0;
      step_pending <= 1'b0;
      spd <= '0;
      nx <= '0;
      ny <= '0;
      ndx <= 1'b0;
      ndy <= 1'b0;
      hx <= 1'b0;
      hy <= 1'b0;
      logo_left <= 10'(START_X);
      logo_top <= 10'(START_Y);
      dir_x <= 1'b1;
      dir_y <= 1'b0;
      color_index <= '0;
      bounce <= 1'b0;
      corner_hit <= 1'b0;
    end else begin
      prev_vpos <= vpos;
      step_pending <= step || (step_pending && !accept);
      bounce <= state == COMMIT && (hx || hy);
      corner_hit <= state == COMMIT && hx && hy;
      if (accept) spd <= speed;
      if (state == CALC_X) {nx, ndx, hx} <= {calc_pos, cur_dir ^ calc_hit, calc_hit};
      if (state == CALC_Y) {ny, ndy, hy} <= {calc_pos, cur_dir ^ calc_hit, calc_hit};
      if (state == COMMIT) begin
        logo_left <= nx;
        logo_top <= ny;
        dir_x <= ndx;
        dir_y <= ndy;
        color_index <= color_index + 3'(hx || hy);
      end
    end
  end
endmodule

// File: tb/tb_logo_motion_controller.sv
// tb_logo_motion_controller: directed bench for the bouncing logo sequencer
module tb_logo_motion_controller;
  logic clk = 1'b0;
  logic reset, pause, step;
  logic [9:0] vpos;
  logic [2:0] speed;
  logic [9:0] logo_left, logo_top;
  logic dir_x, dir_y, bounce, corner_hit, busy;
  logic [2:0] color_index;
  int n_checks = 0;
  int n_fail = 0;
  bit bound_en = 1'b0;
  int m_left, m_top, m_dx, m_dy, m_ci, ux, uy, e_b, e_c, c0, nb;
  always #5 clk = ~clk;
  logo_motion_controller dut (
    .clk(clk), .reset(reset), .vpos(vpos), .speed(speed), .pause(pause), .step(step),
    .logo_left(logo_left), .logo_top(logo_top), .dir_x(dir_x), .dir_y(dir_y),
    .color_index(color_index), .bounce(bounce), .corner_hit(corner_hit), .busy(busy)
  );
  always @(negedge clk) begin
    if (bound_en) begin
      n_checks++;
      assert (logo_left <= 10'd512 && logo_top <= 10'd352) else begin
        n_fail++;
        $error("FAIL bounds: observed left=%0d top=%0d, required left<=512 top<=352", logo_left, logo_top);
      end
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_left = 200;
    m_top = 200;
    m_dx = 1;
    m_dy = 0;
    m_ci = 0;
    e_b = 0;
    e_c = 0;
  endtask
  task automatic model_step(input int s);
    int rx, ry, mx, my;
    bit hx, hy;
    rx = m_dx ? 512 - m_left : m_left;
    ry = m_dy ? 352 - m_top : m_top;
    hx = s > 0 && s >= rx;
    hy = s > 0 && s >= ry;
    mx = hx ? rx : s;
    my = hy ? ry : s;
    m_left += m_dx ? mx : -mx;
    m_top += m_dy ? my : -my;
    if (hx) m_dx = 1 - m_dx;
    if (hy) m_dy = 1 - m_dy;
    e_b = (hx || hy) ? 1 : 0;
    e_c = (hx && hy) ? 1 : 0;
    if (e_b != 0) m_ci = (m_ci + 1) % 8;
    ux += mx;
    uy += my;
  endtask
  task automatic check_all();
    chk("left", logo_left, m_left);
    chk("top", logo_top, m_top);
    chk("dir_x", dir_x, m_dx);
    chk("dir_y", dir_y, m_dy);
    chk("color_index", color_index, m_ci);
    chk("bounce", bounce, e_b);
    chk("corner_hit", corner_hit, e_c);
    chk("busy_idle", busy, 0);
  endtask
  task automatic run_frame(input int s, input bit upd);
    speed = 3'(s);
    vpos = 10'd524;
    cyc();
    vpos = 10'd0;
    cyc();
    chk("busy_after_tick", busy, upd);
    vpos = 10'd1;
    cyc();
    cyc();
    cyc();
    if (upd) model_step(s);
    else begin
      e_b = 0;
      e_c = 0;
    end
    check_all();
  endtask
  initial begin
    reset = 1'b1;
    vpos = 10'd0;
    speed = 3'd3;
    pause = 1'b0;
    step = 1'b0;
    ux = 0;
    uy = 0;
    model_reset();
    cyc();
    cyc();
    check_all();
    reset = 1'b0;
    bound_en = 1'b1;
    vpos = 10'd524;
    cyc();
    vpos = 10'd0;
    cyc();
    chk("t1_busy1", busy, 1);
    vpos = 10'd1;
    cyc();
    chk("t1_busy2", busy, 1);
    cyc();
    chk("t1_busy3", busy, 1);
    chk("t1_left_hold", logo_left, 200);
    cyc();
    chk("t1_busy_done", busy, 0);
    chk("t1_left", logo_left, 203);
    chk("t1_top", logo_top, 197);
    chk("t1_bounce", bounce, 0);
    model_step(3);
    check_all();
    repeat (196) run_frame(1, 1);
    chk("t2_left_pre", logo_left, 399);
    chk("t2_top_pre", logo_top, 1);
    run_frame(1, 1);
    chk("t2_top", logo_top, 0);
    chk("t2_dir_y", dir_y, 1);
    chk("t2_ci", color_index, 1);
    chk("t2_bounce", bounce, 1);
    chk("t2_left", logo_left, 400);
    cyc();
    chk("t2_bounce_drop", bounce, 0);
    ux = 0;
    uy = 0;
    for (int f = 0; f < 1000 && ux != 3182; f++) begin
      int rx, ry, need, s;
      rx = m_dx ? 512 - m_left : m_left;
      ry = m_dy ? 352 - m_top : m_top;
      need = 16 - (ux - uy);
      s = 7;
      if (rx < s) s = rx;
      if (need > 0 && ry >= 7) begin
        if (ry - 1 < s) s = ry - 1;
      end else if (ry + need < s) s = ry + need;
      if (3182 - ux < s) s = 3182 - ux;
      run_frame(s, 1);
    end
    chk("t3_left_pre", logo_left, 510);
    chk("t3_top_pre", logo_top, 350);
    chk("t3_dx_pre", dir_x, 1);
    chk("t3_dy_pre", dir_y, 1);
    c0 = m_ci;
    run_frame(4, 1);
    chk("t3_left", logo_left, 512);
    chk("t3_top", logo_top, 352);
    chk("t3_dx", dir_x, 0);
    chk("t3_dy", dir_y, 0);
    chk("t3_ci_once", color_index, (c0 + 1) % 8);
    chk("t3_bounce", bounce, 1);
    chk("t3_corner", corner_hit, 1);
    cyc();
    chk("t3_bounce_drop", bounce, 0);
    chk("t3_corner_drop", corner_hit, 0);
    run_frame(0, 1);
    chk("t4_spd0_left", logo_left, 512);
    chk("t4_spd0_top", logo_top, 352);
    chk("t4_spd0_bounce", bounce, 0);
    pause = 1'b1;
    repeat (3) run_frame(5, 0);
    chk("t4_pause_left", logo_left, 512);
    step = 1'b1;
    cyc();
    step = 1'b0;
    run_frame(5, 1);
    chk("t4_step_left", logo_left, 507);
    chk("t4_step_top", logo_top, 347);
    run_frame(5, 0);
    chk("t4_step_once", logo_left, 507);
    pause = 1'b0;
    reset = 1'b1;
    vpos = 10'd0;
    cyc();
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t5_hold_vpos0_busy", busy, 0);
    end
    run_frame(3, 1);
    vpos = 10'd524;
    cyc();
    vpos = 10'd0;
    cyc();
    vpos = 10'd1;
    cyc();
    chk("t5_busy_calc_y", busy, 1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    model_reset();
    check_all();
    cyc();
    cyc();
    cyc();
    check_all();
    chk("t5_no_commit_left", logo_left, 200);
    nb = 0;
    for (int f = 0; f < 2000 && nb < 9; f++) begin
      run_frame(7, 1);
      if (e_b != 0) nb++;
    end
    chk("t6_ci_wrap", color_index, 1);
    bound_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
